quadrature_decoder: RTL



---
 rtl/quadrature_decoder.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/quadrature_decoder.sv
// -----------------------------------------------------------------------------
// quadrature_decoder
//
// Decodes CHANNELS independent A/B quadrature encoder inputs. Each raw input
// bit is passed through a two-flop synchroniser and a counter-based debouncer.
// The debounced {a,b} state is decoded at 1x, 2x or 4x resolution into
// one-cycle cw/ccw pulses, a signed position counter (wrapping or saturating)
// and a sticky illegal-transition flag.
//
// Ports:
//   clk       sole clock, rising edge
//   rst_n     asynchronous active-low reset
//   in_a      [CHANNELS]        raw A inputs (asynchronous)
//   in_b      [CHANNELS]        raw B inputs (asynchronous)
//   clear     [CHANNELS]        synchronous clear of position and error
//   out_cw    [CHANNELS]        one-cycle clockwise step pulse
//   out_ccw   [CHANNELS]        one-cycle counter-clockwise step pulse
//   position  [CHANNELS*WIDTH]  channel n at bits [n*WIDTH +: WIDTH]
//   error     [CHANNELS]        sticky illegal-transition flag
// -----------------------------------------------------------------------------
module quadrature_decoder #(
    parameter int CHANNELS        = 1,
    parameter int WIDTH           = 16,
    parameter int DEBOUNCE_CYCLES = 100,
    parameter int COUNT_MODE      = 1,
    parameter int SATURATE        = 0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS-1:0]       in_a,
    input  logic [CHANNELS-1:0]       in_b,
    input  logic [CHANNELS-1:0]       clear,
    output logic [CHANNELS-1:0]       out_cw,
    output logic [CHANNELS-1:0]       out_ccw,
    output logic [CHANNELS*WIDTH-1:0] position,
    output logic [CHANNELS-1:0]       error
);

    localparam int PRIME_LEN = DEBOUNCE_CYCLES + 2;
    localparam int PW        = $clog2(PRIME_LEN + 1);
    localparam int CW        = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]    CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [PW-1:0]    PRIME_END = PW'(PRIME_LEN);
    localparam logic [WIDTH-1:0] POS_MAX  = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] POS_MIN  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam bit               SAT_EN   = (SATURATE != 0);

    // Next state along the clockwise Gray sequence 00->01->11->10->00.
    function automatic logic [1:0] cw_next(input logic [1:0] s);
        logic [1:0] n;
        case (s)
            2'b00:   n = 2'b01;
            2'b01:   n = 2'b11;
            2'b11:   n = 2'b10;
            default: n = 2'b00;
        endcase
        return n;
    endfunction

    // Whether leaving state s counts at the configured resolution.
    function automatic logic counts_from(input logic [1:0] s);
        logic r;
        case (COUNT_MODE)
            4:       r = 1'b1;
            2:       r = (s == 2'b00) || (s == 2'b11);
            default: r = (s == 2'b00);
        endcase
        return r;
    endfunction

    logic [PW-1:0] prime_cnt_r;
    logic          priming_s;

    // While priming, debounced bits track the synchroniser so the idle-high
    // reset value cannot be mistaken for a real transition.
    assign priming_s = (prime_cnt_r != PRIME_END);

    // Priming counter: runs once after reset deassertion, then holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prime_cnt_r <= {PW{1'b0}};
        end else if (priming_s) begin
            prime_cnt_r <= prime_cnt_r + PW'(1);
        end else begin
            prime_cnt_r <= prime_cnt_r;
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        logic [1:0]       sync1_r;
        logic [1:0]       sync2_r;
        logic [1:0]       deb_r;
        logic [1:0]       prev_r;
        logic [CW-1:0]    cnt_r [2];
        logic             step_cw_s;
        logic             step_ccw_s;
        logic             illegal_s;
        logic [WIDTH-1:0] pos_next_s;
        logic             cw_r;
        logic             ccw_r;
        logic             err_r;
        logic [WIDTH-1:0] pos_r;

        // Two-flop synchroniser for {a,b}; resets to the pull-up idle level.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sync1_r <= 2'b11;
                sync2_r <= 2'b11;
            end else begin
                sync1_r <= {in_a[g], in_b[g]};
                sync2_r <= sync1_r;
            end
        end

        // Per-bit debouncer: accept a new level after DEBOUNCE_CYCLES
        // consecutive disagreeing samples; any agreeing sample restarts it.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                deb_r    <= 2'b11;
                cnt_r[0] <= {CW{1'b0}};
                cnt_r[1] <= {CW{1'b0}};
            end else if (priming_s) begin
                deb_r    <= sync2_r;
                cnt_r[0] <= {CW{1'b0}};
                cnt_r[1] <= {CW{1'b0}};
            end else begin
                for (int k = 0; k < 2; k++) begin
                    if (sync2_r[k] == deb_r[k]) begin
                        cnt_r[k] <= {CW{1'b0}};
                    end else if (cnt_r[k] == CNT_LAST) begin
                        deb_r[k] <= sync2_r[k];
                        cnt_r[k] <= {CW{1'b0}};
                    end else begin
                        cnt_r[k] <= cnt_r[k] + CW'(1);
                    end
                end
            end
        end

        // Previous debounced state; forced equal to the incoming value while
        // priming so the first normal cycle sees no transition.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                prev_r <= 2'b11;
            end else if (priming_s) begin
                prev_r <= sync2_r;
            end else begin
                prev_r <= deb_r;
            end
        end

        // Transition decode: both bits changing is illegal, one bit changing
        // is a step only when leaving a counting state.
        always_comb begin
            step_cw_s  = 1'b0;
            step_ccw_s = 1'b0;
            illegal_s  = 1'b0;
            case (prev_r ^ deb_r)
                2'b11: begin
                    illegal_s = 1'b1;
                end
                2'b01, 2'b10: begin
                    if (counts_from(prev_r)) begin
                        if (deb_r == cw_next(prev_r)) begin
                            step_cw_s = 1'b1;
                        end else begin
                            step_ccw_s = 1'b1;
                        end
                    end else begin
                        step_cw_s = 1'b0;
                    end
                end
                default: begin
                    illegal_s = 1'b0;
                end
            endcase
        end

        // Position arithmetic with optional clamping at the signed limits.
        always_comb begin
            pos_next_s = pos_r;
            if (step_cw_s) begin
                if (SAT_EN && (pos_r == POS_MAX)) begin
                    pos_next_s = pos_r;
                end else begin
                    pos_next_s = pos_r + WIDTH'(1);
                end
            end else if (step_ccw_s) begin
                if (SAT_EN && (pos_r == POS_MIN)) begin
                    pos_next_s = pos_r;
                end else begin
                    pos_next_s = pos_r - WIDTH'(1);
                end
            end else begin
                pos_next_s = pos_r;
            end
        end

        // Registered outputs; clear overrides position/error but not pulses.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cw_r  <= 1'b0;
                ccw_r <= 1'b0;
                err_r <= 1'b0;
                pos_r <= {WIDTH{1'b0}};
            end else begin
                cw_r  <= step_cw_s && !priming_s;
                ccw_r <= step_ccw_s && !priming_s;
                if (clear[g]) begin
                    pos_r <= {WIDTH{1'b0}};
                    err_r <= 1'b0;
                end else if (!priming_s) begin
                    pos_r <= pos_next_s;
                    err_r <= err_r | illegal_s;
                end else begin
                    pos_r <= pos_r;
                    err_r <= err_r;
                end
            end
        end

        assign out_cw[g]                     = cw_r;
        assign out_ccw[g]                    = ccw_r;
        assign error[g]                      = err_r;
        assign position[g*WIDTH +: WIDTH]    = pos_r;
    end

endmodule
